// File: rtl/key_history_echo_pkg.sv
// Shared types and constants for the key history echo display path.
// Contents: history entry layout, refresh FSM encoding, segment bit order, hex glyph table.
// Latency/backpressure: none (declarations only).
package key_history_echo_pkg;

    // One history entry: valid + rls + xpd + 8-bit scan code.
    localparam int ENTRY_W = 11;

    // Segment byte is {dp,g,f,e,d,c,b,a}; values here are active-high (1 = lit).
    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam int         SEG_DP    = 7;

    typedef struct packed {
        logic       valid;
        logic       rls;
        logic       xpd;
        logic [7:0] key;
    } entry_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_DONE
    } state_t;

    // Active-high {g,f,e,d,c,b,a} glyph for one hex digit.
    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0: g = 7'h3F;
            4'h1: g = 7'h06;
            4'h2: g = 7'h5B;
            4'h3: g = 7'h4F;
            4'h4: g = 7'h66;
            4'h5: g = 7'h6D;
            4'h6: g = 7'h7D;
            4'h7: g = 7'h07;
            4'h8: g = 7'h7F;
            4'h9: g = 7'h6F;
            4'hA: g = 7'h77;
            4'hB: g = 7'h7C;
            4'hC: g = 7'h39;
            4'hD: g = 7'h5E;
            4'hE: g = 7'h79;
            default: g = 7'h71;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/key_history_echo_if.sv
// Key event input + serial 7-segment output bundle for key_history_echo.
// master: event source (start/key/rls/xpd/mode/clear_hist); slave: the display engine.
// No backpressure: events are pulses, busy is informational only.
interface key_history_echo_if #(
    parameter int DIGITS = 8
);
    localparam int CNT_W = $clog2(DIGITS / 2 + 1);

    logic             start;
    logic [7:0]       key;
    logic             rls;
    logic             xpd;
    logic             mode;
    logic             clear_hist;
    logic             busy;
    logic [CNT_W-1:0] evt_count;
    logic             SEG_CLK;
    logic             SEG_CLR;
    logic             SEG_DT;
    logic             SEG_EN;

    modport master (
        output start, key, rls, xpd, mode, clear_hist,
        input  busy, evt_count, SEG_CLK, SEG_CLR, SEG_DT, SEG_EN
    );

    modport slave (
        input  start, key, rls, xpd, mode, clear_hist,
        output busy, evt_count, SEG_CLK, SEG_CLR, SEG_DT, SEG_EN
    );

endinterface

// File: rtl/key_history_echo_hex_to_seg.sv
// Hex nibble to one 7-segment byte {dp,g,f,e,d,c,b,a}, with blanking and output polarity.
// Ports: nib/dp/blank in, seg out. Purely combinational, zero latency.
// No backpressure.
module hex_to_seg
    import key_history_echo_pkg::*;
#(
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic [3:0] nib,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] seg
);

    logic [7:0] lit;

    always_comb begin
        lit = SEG_BLANK;
        if (!blank) begin
            lit[6:0]   = hex_glyph(nib);
            lit[SEG_DP] = dp;
        end
        seg = (SEG_ACTIVE_LOW != 0) ? ~lit : lit;
    end

endmodule

// File: rtl/key_history_echo.sv
// Key event history/echo buffer driving a serial shift-register 7-segment chain.
// Ports: clk, rst (sync, active-high), bus (slave: events in, busy/evt_count/SEG_* out).
// Latency: frame = 1 + 2*CLK_DIV*8*DIGITS + 1 clk; events never stall, mid-frame events queue one refresh.
module key_history_echo
    import key_history_echo_pkg::*;
#(
    parameter int DIGITS         = 8,
    parameter int CLK_DIV        = 4,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic              clk,
    input  logic              rst,
    key_history_echo_if.slave bus
);

    localparam int DEPTH   = DIGITS / 2;
    localparam int FRAME_W = 8 * DIGITS;
    localparam int BIT_W   = $clog2(FRAME_W);
    localparam int DIV_W   = $clog2(CLK_DIV + 1);
    localparam int CNT_W   = $clog2(DEPTH + 1);

    state_t               state_q, state_d;
    entry_t               entries_q [DEPTH];
    entry_t               entries_d [DEPTH];
    entry_t               hist_base [DEPTH];
    logic [CNT_W-1:0]     evt_count_q, evt_count_d;
    logic                 pending_q, pending_d;
    logic                 mode_seen_q, mode_seen_d;
    logic [FRAME_W-1:0]   shreg_q, shreg_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic                 seg_clr_q, seg_clr_d;
    logic                 seg_en_q, seg_en_d;

    logic                 div_last;
    logic [ENTRY_W-1:0]   new_entry;
    logic [FRAME_W-1:0]   frame;
    logic [3:0]           dig_nib   [DIGITS];
    logic                 dig_dp    [DIGITS];
    logic                 dig_blank [DIGITS];

    assign div_last  = (div_q == DIV_W'(CLK_DIV - 1));
    assign new_entry = {1'b1, bus.rls, bus.xpd, bus.key};

    // State register and all datapath flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
            evt_count_q <= '0;
            pending_q   <= 1'b1;
            mode_seen_q <= 1'b0;
            shreg_q     <= '0;
            bit_q       <= '0;
            div_q       <= '0;
            seg_clr_q   <= 1'b0;
            seg_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            for (int i = 0; i < DEPTH; i++) entries_q[i] <= entries_d[i];
            evt_count_q <= evt_count_d;
            pending_q   <= pending_d;
            mode_seen_q <= mode_seen_d;
            shreg_q     <= shreg_d;
            bit_q       <= bit_d;
            div_q       <= div_d;
            seg_clr_q   <= seg_clr_d;
            seg_en_q    <= seg_en_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (pending_q) state_d = ST_LOAD;
            ST_LOAD:     state_d = ST_SHIFT_LO;
            ST_SHIFT_LO: if (div_last) state_d = ST_SHIFT_HI;
            ST_SHIFT_HI: if (div_last) state_d = (bit_q == '0) ? ST_DONE : ST_SHIFT_LO;
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // History buffer: clear applies before a same-cycle store.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            hist_base[i] = bus.clear_hist ? '0 : entries_q[i];
            entries_d[i] = hist_base[i];
        end
        evt_count_d = bus.clear_hist ? '0 : evt_count_q;
        if (bus.start) begin
            for (int i = DEPTH - 1; i > 0; i--) entries_d[i] = hist_base[i-1];
            entries_d[0] = entry_t'(new_entry);
            if (evt_count_d != CNT_W'(DEPTH)) evt_count_d = evt_count_d + 1'b1;
        end
    end

    // Shifter, divider and refresh request. A new event wins over LOAD clearing
    // pending, so an event in the LOAD cycle still earns its own frame.
    always_comb begin
        shreg_d     = shreg_q;
        bit_d       = bit_q;
        div_d       = '0;
        pending_d   = pending_q;
        mode_seen_d = bus.mode;
        seg_clr_d   = 1'b1;
        seg_en_d    = 1'b1;
        if (state_q == ST_SHIFT_LO || state_q == ST_SHIFT_HI)
            div_d = div_last ? '0 : div_q + 1'b1;
        if (state_q == ST_LOAD) begin
            shreg_d   = frame;
            bit_d     = BIT_W'(FRAME_W - 1);
            pending_d = 1'b0;
        end
        if (state_q == ST_SHIFT_HI && div_last) begin
            shreg_d = shreg_q << 1;
            bit_d   = bit_q - 1'b1;
        end
        if (bus.start || bus.clear_hist || (bus.mode != mode_seen_q))
            pending_d = 1'b1;
    end

    // Per-digit glyph selection; mode is taken live, so it is sampled in LOAD.
    always_comb begin
        for (int d = 0; d < DIGITS; d++) begin
            dig_nib[d]   = 4'h0;
            dig_dp[d]    = 1'b0;
            dig_blank[d] = 1'b1;
            if (bus.mode) begin
                dig_nib[d]   = (d % 2 == 1) ? entries_q[d/2].key[7:4] : entries_q[d/2].key[3:0];
                dig_dp[d]    = (d % 2 == 0) && entries_q[d/2].rls;
                dig_blank[d] = !entries_q[d/2].valid;
            end else if (d < 4) begin
                // An invalid newest entry shows as 0 0 0 0.
                dig_blank[d] = 1'b0;
                if (entries_q[0].valid) begin
                    case (d)
                        3:       dig_nib[d] = {3'b000, entries_q[0].xpd};
                        2:       dig_nib[d] = {3'b000, entries_q[0].rls};
                        1:       dig_nib[d] = entries_q[0].key[7:4];
                        default: dig_nib[d] = entries_q[0].key[3:0];
                    endcase
                end
            end
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        hex_to_seg #(
            .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
        ) u_seg (
            .nib  (dig_nib[g]),
            .dp   (dig_dp[g]),
            .blank(dig_blank[g]),
            .seg  (frame[8*g +: 8])
        );
    end

    // Moore outputs decoded from state.
    always_comb begin
        bus.SEG_CLK   = (state_q == ST_SHIFT_HI);
        bus.SEG_DT    = (state_q == ST_SHIFT_LO || state_q == ST_SHIFT_HI) ? shreg_q[FRAME_W-1] : 1'b0;
        bus.busy      = (state_q == ST_LOAD || state_q == ST_SHIFT_LO || state_q == ST_SHIFT_HI);
        bus.SEG_CLR   = seg_clr_q;
        bus.SEG_EN    = seg_en_q;
        bus.evt_count = evt_count_q;
    end

endmodule

// File: tb/tb_key_history_echo.sv
// Self-checking bench for key_history_echo (DIGITS=8, CLK_DIV=4, active-low segments).
// Captures shifted frames from SEG_CLK/SEG_DT and compares them with a queue-based history model.
// Summary line reports total checks and failures.
module tb_key_history_echo;

    localparam int DIGITS    = 8;
    localparam int CLK_DIV   = 4;
    localparam int DEPTH     = DIGITS / 2;
    localparam int BUSY_LEN  = 1 + 2 * CLK_DIV * 8 * DIGITS;
    localparam int BUDGET    = 3000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    key_history_echo_if #(.DIGITS(DIGITS)) bus ();

    key_history_echo #(
        .DIGITS(DIGITS),
        .CLK_DIV(CLK_DIV),
        .SEG_ACTIVE_LOW(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference history: newest at index 0, each entry {rls, xpd, key}.
    logic [9:0] hist [$];

    // Frame monitor: only this block writes these.
    logic [63:0] frames [64];
    int          frame_wr  = 0;
    int          mon_bits  = 0;
    int          busy_cnt  = 0;
    logic [63:0] mon_cur   = '0;
    logic        sclk_prev = 1'b0;
    int          frame_rd  = 0;

    always @(negedge clk) begin
        if (rst) begin
            mon_bits  = 0;
            sclk_prev = 1'b0;
        end else begin
            if (bus.SEG_CLK && !sclk_prev) begin
                mon_cur  = {mon_cur[62:0], bus.SEG_DT};
                mon_bits = mon_bits + 1;
                if (mon_bits == 64) begin
                    frames[frame_wr % 64] = mon_cur;
                    frame_wr = frame_wr + 1;
                    mon_bits = 0;
                end
            end
            sclk_prev = bus.SEG_CLK;
            if (bus.busy) busy_cnt = busy_cnt + 1;
        end
    end

    function automatic logic [7:0] glyph(input logic [3:0] n);
        logic [7:0] g;
        case (n)
            4'h0: g = 8'h3F; 4'h1: g = 8'h06; 4'h2: g = 8'h5B; 4'h3: g = 8'h4F;
            4'h4: g = 8'h66; 4'h5: g = 8'h6D; 4'h6: g = 8'h7D; 4'h7: g = 8'h07;
            4'h8: g = 8'h7F; 4'h9: g = 8'h6F; 4'hA: g = 8'h77; 4'hB: g = 8'h7C;
            4'hC: g = 8'h39; 4'hD: g = 8'h5E; 4'hE: g = 8'h79; default: g = 8'h71;
        endcase
        return g;
    endfunction

    // Expected 64-bit frame, leftmost digit in the top byte, active-low.
    function automatic logic [63:0] exp_frame(input bit m);
        logic [7:0]  dig [DIGITS];
        logic [9:0]  e;
        logic [63:0] f;
        for (int d = 0; d < DIGITS; d++) dig[d] = 8'h00;
        if (!m) begin
            e = (hist.size() > 0) ? hist[0] : 10'h000;
            dig[3] = glyph({3'b000, e[8]});
            dig[2] = glyph({3'b000, e[9]});
            dig[1] = glyph(e[7:4]);
            dig[0] = glyph(e[3:0]);
        end else begin
            for (int i = 0; i < hist.size(); i++) begin
                e = hist[i];
                dig[2*i+1] = glyph(e[7:4]);
                dig[2*i]   = glyph(e[3:0]) | (e[9] ? 8'h80 : 8'h00);
            end
        end
        for (int d = 0; d < DIGITS; d++) f[8*d +: 8] = ~dig[d];
        return f;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Apply one event pulse and update the model (clear before store).
    task automatic ev(input logic s, input logic c, input logic [7:0] k, input logic r, input logic x);
        bus.start = s; bus.clear_hist = c; bus.key = k; bus.rls = r; bus.xpd = x;
        @(negedge clk);
        bus.start = 1'b0; bus.clear_hist = 1'b0;
        if (c) hist.delete();
        if (s) begin
            hist.push_front({r, x, k});
            if (hist.size() > DEPTH) void'(hist.pop_back());
        end
    endtask

    task automatic wait_frame(input string tag, output logic [63:0] f);
        int n = 0;
        while (frame_wr == frame_rd && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (frame_wr != frame_rd) else begin
            failures++;
            $error("FAIL %s frame timeout observed=none expected=frame", tag);
        end
        f = (frame_wr != frame_rd) ? frames[frame_rd % 64] : 64'hx;
        if (frame_wr != frame_rd) frame_rd++;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        int low = 0;
        while (low < 4 && n < BUDGET) begin
            @(negedge clk);
            n++;
            low = bus.busy ? 0 : low + 1;
        end
        checks++;
        assert (low >= 4) else begin
            failures++;
            $error("FAIL %s idle timeout observed=busy expected=idle", tag);
        end
    endtask

    initial begin
        logic [63:0] f;
        logic [63:0] exp1;
        logic [7:0]  k;
        int b0, w0, n;

        bus.start = 1'b0; bus.clear_hist = 1'b0; bus.key = 8'h00;
        bus.rls = 1'b0; bus.xpd = 1'b0; bus.mode = 1'b0;

        // Reset values
        cycles(3);
        chk("rst_seg_clr", bus.SEG_CLR, 0);
        chk("rst_seg_en", bus.SEG_EN, 0);
        chk("rst_seg_clk", bus.SEG_CLK, 0);
        chk("rst_seg_dt", bus.SEG_DT, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_evt_count", bus.evt_count, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_seg_clr", bus.SEG_CLR, 1);
        chk("post_rst_seg_en", bus.SEG_EN, 1);

        // Power-up ECHO frame, then silence
        wait_frame("boot", f);
        chk("boot_frame_const", f, 64'hFFFFFFFF_C0C0C0C0);
        chk("boot_frame_model", f, exp_frame(0));
        wait_idle("boot");
        b0 = busy_cnt; w0 = frame_wr;
        cycles(50);
        chk("boot_quiet_busy", busy_cnt - b0, 0);
        chk("boot_quiet_frames", frame_wr - w0, 0);

        // ECHO directed: 0x1C release
        ev(1, 0, 8'h1C, 1, 0);
        wait_frame("echo_1c", f);
        chk("echo_1c_frame", f, exp_frame(0));
        chk("echo_1c_last_byte", f[7:0], 8'hC6);
        wait_idle("echo_1c");
        chk("echo_1c_evt_count", bus.evt_count, 1);

        // ECHO random events
        for (int i = 0; i < 3; i++) begin
            ev(1, 0, 8'($urandom_range(0, 255)), 1'($urandom), 1'($urandom));
            wait_frame("echo_rand", f);
            chk("echo_rand_frame", f, exp_frame(0));
            wait_idle("echo_rand");
            chk("echo_rand_evt_count", bus.evt_count, hist.size());
        end

        // Mode change alone refreshes the display
        bus.mode = 1'b1;
        wait_frame("mode_hist", f);
        chk("mode_hist_frame", f, exp_frame(1));
        wait_idle("mode_hist");

        // HISTORY directed: 0x1C drops out, 0x21 carries the release dp
        ev(1, 1, 8'h1C, 0, 0);
        wait_frame("hist_seq", f);
        chk("hist_seq_frame0", f, exp_frame(1));
        wait_idle("hist_seq");
        ev(1, 0, 8'h32, 0, 0); wait_frame("hist_seq", f); chk("hist_seq_frame1", f, exp_frame(1)); wait_idle("hist_seq");
        ev(1, 0, 8'h21, 1, 0); wait_frame("hist_seq", f); chk("hist_seq_frame2", f, exp_frame(1)); wait_idle("hist_seq");
        ev(1, 0, 8'h23, 0, 0); wait_frame("hist_seq", f); chk("hist_seq_frame3", f, exp_frame(1)); wait_idle("hist_seq");
        ev(1, 0, 8'h24, 0, 1); wait_frame("hist_seq", f); chk("hist_seq_frame4", f, exp_frame(1)); wait_idle("hist_seq");
        chk("hist_seq_const", f, 64'hB0A4A479_A4B0A499);
        chk("hist_seq_evt_count", bus.evt_count, 4);

        // Two events during one frame: frame in flight unchanged, one extra frame
        b0 = busy_cnt;
        ev(1, 0, 8'($urandom_range(0, 255)), 1'($urandom), 0);
        exp1 = exp_frame(1);
        cycles(100);
        ev(1, 0, 8'($urandom_range(0, 255)), 1'($urandom), 1'($urandom));
        cycles(150);
        ev(1, 0, 8'($urandom_range(0, 255)), 1'($urandom), 1'($urandom));
        wait_frame("burst_f1", f);
        chk("burst_frame1", f, exp1);
        wait_frame("burst_f2", f);
        chk("burst_frame2", f, exp_frame(1));
        wait_idle("burst");
        cycles(20);
        chk("burst_no_third", frame_wr - frame_rd, 0);
        chk("burst_busy_cycles", busy_cnt - b0, 2 * BUSY_LEN);

        // Clear and start together
        ev(1, 1, 8'h5A, 0, 0);
        wait_frame("clr_start", f);
        chk("clr_start_frame", f, exp_frame(1));
        chk("clr_start_const", f, 64'hFFFFFFFF_FFFF9288);
        wait_idle("clr_start");
        chk("clr_start_evt_count", bus.evt_count, 1);

        // HISTORY random with occasional clears
        for (int i = 0; i < 5; i++) begin
            k = 8'($urandom_range(0, 255));
            ev(1, ($urandom_range(0, 3) == 0), k, 1'($urandom), 1'($urandom));
            wait_frame("hist_rand", f);
            chk("hist_rand_frame", f, exp_frame(1));
            wait_idle("hist_rand");
            chk("hist_rand_evt_count", bus.evt_count, hist.size());
        end

        // Reset in the middle of a frame
        ev(1, 0, 8'($urandom_range(0, 255)), 0, 0);
        n = 0;
        while (mon_bits != 30 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        chk("mid_rst_reach_bit30", mon_bits, 30);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_seg_clk", bus.SEG_CLK, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_seg_clr", bus.SEG_CLR, 0);
        hist.delete();
        @(negedge clk);
        rst = 1'b0;
        wait_frame("mid_rst_fresh", f);
        chk("mid_rst_fresh_frame", f, exp_frame(1));
        chk("mid_rst_fresh_const", f, 64'hFFFFFFFF_FFFFFFFF);
        wait_idle("mid_rst");
        cycles(20);
        chk("mid_rst_single_frame", frame_wr - frame_rd, 0);
        chk("mid_rst_evt_count", bus.evt_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/key_history_echo.md
Name: key_history_echo

Overview:
- Parametrised successor to the single-event keyboard echo: captures PS/2 key events (scan code, release flag, extended flag) and drives the serial shift-register 7-segment display directly.
- Two modes:
  - ECHO: latest event only, shown as xpd/rls/code.
  - HISTORY: the last DIGITS/2 key codes, newest on the right; a decimal point marks a release event.
- Sits between the PS/2 decoder and the board's serial 7-segment chain. It replaces the fixed 32-bit number path with its own segment encoder and shifter.

Parameters:
- DIGITS, 8, number of 7-segment digits in the chain. Must be even and ≥2. History depth is DEPTH = DIGITS/2.
- CLK_DIV, 4, clk cycles per SEG_CLK half-period. Must be ≥1.
- SEG_ACTIVE_LOW, 1, 1 means a segment bit of 0 lights that segment.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse: new key event on key/rls/xpd
- key  in  8  scan code
- rls  in  1  event is a key release (break)
- xpd  in  1  event is an extended (E0) code
- mode  in  1  0 = ECHO, 1 = HISTORY; sampled at LOAD
- clear_hist  in  1  one-cycle pulse: empty history, refresh display
- busy  out  1  high while a frame is being shifted
- evt_count  out  $clog2(DEPTH+1)  valid history entries, saturating at DEPTH
- SEG_CLK  out  1  serial shift clock; data shifts on its rising edge
- SEG_CLR  out  1  active-low clear of the external chain
- SEG_DT  out  1  serial data
- SEG_EN  out  1  display enable

Behaviour:
- Reset values:
  - SEG_CLK=0, SEG_DT=0, SEG_CLR=0 (held low while rst is high), SEG_EN=0, busy=0, evt_count=0.
  - History entries invalid; pending=1, so a blank or ECHO "00 00" frame is pushed right after reset.
  - First clk after rst falls: SEG_CLR=1, SEG_EN=1.
- History buffer: DEPTH entries of {valid, rls, xpd, key}, held in a shift register.
  - On start: entry[0] ← {1, rls, xpd, key}, entry[i] ← entry[i-1]. The oldest entry is dropped once full.
  - evt_count saturates at DEPTH.
- clear_hist invalidates all entries and sets evt_count=0.
  - If start and clear_hist arrive in the same cycle, clear applies first, then the new event is stored (evt_count=1).
- Frame content (8*DIGITS bits; digit DIGITS-1 first, bit 7 first; byte = {dp,g,f,e,d,c,b,a}):
  - ECHO: digits 3..0 = hex xpd, hex rls, key[7:4], key[3:0], all taken from entry[0]. Upper digits blank. If entry[0] is invalid, show 0,0,0,0.
  - HISTORY: entry[i] occupies digits 2i+1 and 2i as key hex. The dp of digit 2i is lit iff rls. Invalid entries are blank.
- Refresh FSM states: IDLE, LOAD, SHIFT_LO, SHIFT_HI, DONE.
  - IDLE→LOAD when pending. LOAD clears pending, latches mode and the frame into the shift register, sets bit counter = 8*DIGITS−1, raises busy.
  - SHIFT_LO: SEG_CLK=0, SEG_DT=current MSB, held CLK_DIV cycles → SHIFT_HI.
  - SHIFT_HI: SEG_CLK=1, held CLK_DIV cycles. At exit, shift left and decrement. Counter==0 at exit → DONE, otherwise → SHIFT_LO.
  - DONE: SEG_CLK=0, busy=0 for one cycle → IDLE.
- pending is set by start, clear_hist, or a change in mode, in any state. An event that lands mid-frame does not corrupt the frame in flight; it triggers exactly one further frame after DONE. Multiple events during one frame still produce one further frame.
- Frame length: 1 (LOAD) + 2*CLK_DIV*8*DIGITS + 1 (DONE) clk cycles.
  - DIGITS=8, CLK_DIV=4: 514 cycles.
- Reset asserted mid-frame aborts immediately to reset values on the next edge.

Decomposition:
- Shared package: SEG_BLANK constant, segment-bit ordering, FSM state encoding, and the history entry width (10 bits, plus 1 valid bit).
- Sub-module: hex_to_seg (4-bit nibble + dp + blank → 8-bit segment byte, polarity per SEG_ACTIVE_LOW). It is purely combinational; the design instantiates one per digit.

Test Plan:
- Reset, then idle: SEG_CLR=0 during rst, then 1. Exactly one frame of 64 bits; in ECHO mode with 0xC0 digits and active-low, the bytes are 0xFF×4 followed by 0xC0×4. busy then falls and stays low.
- ECHO, start with key=0x1C, rls=1, xpd=0 → digits 3..0 = 0,1,1,C. The last byte shifted is 0xC6. evt_count=1.
- HISTORY, events 0x1C, 0x32, 0x21, 0x23, 0x24 (the third with rls=1) → displays 32 21. 23 24. Only the 0x21 pair's low digit has its dp lit. 0x1C is dropped. evt_count=4.
- Two start pulses during one frame → the current frame completes unchanged, followed by exactly one extra frame showing both events. Total busy-high cycles = 2×514 minus gaps.
- clear_hist and start in the same cycle with key=0x5A → evt_count=1; HISTORY shows only 5A, upper six digits blank.
- rst asserted at bit 30 of a frame → SEG_CLK=0, busy=0, SEG_CLR=0 next cycle. After release, the history is empty and one fresh frame is sent.
